regfile_rename_mp: RTL and testbench

Parametrised architectural register file with rename state for the out-of-order core. Each register holds a value, a ROB tag and a busy bit. The block is the successor to the fixed two-port register/rename table. It adds:
- a configurable number of decoder read ports,
- explicit valid qualifiers on rename and commit,
- same-cycle commit-to-read bypass,
- a global flush that clears all rename state on misprediction.

It sits between the decoder (reads and renames) and the ROB (commits and flushes).

---
 rtl/regfile_rename_mp.sv | 124 ++++++++++++
 tb/tb_regfile_rename_mp.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_rename_mp.sv
// Architectural register file with rename state (value, ROB tag, busy).
// Reads are combinational with a same-cycle commit bypass. Rename and commit
// come with valid qualifiers, and a flush clears every busy bit.
module regfile_rename_mp #(
    parameter int unsigned REG_NUM  = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ROB_W    = 4,
    parameter int unsigned NUM_READ = 2,
    localparam int unsigned IDX_W   = $clog2(REG_NUM),
    localparam int unsigned CNT_W   = $clog2(REG_NUM + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    input  logic [NUM_READ*IDX_W-1:0]    in_rd_idx,
    output logic [NUM_READ*DATA_W-1:0]   out_rd_value,
    output logic [NUM_READ*ROB_W-1:0]    out_rd_tag,
    output logic [NUM_READ-1:0]          out_rd_busy,
    input  logic                         in_ren_valid,
    input  logic [IDX_W-1:0]             in_ren_reg,
    input  logic [ROB_W-1:0]             in_ren_rob,
    input  logic                         in_cmt_valid,
    input  logic [IDX_W-1:0]             in_cmt_reg,
    input  logic [ROB_W-1:0]             in_cmt_rob,
    input  logic [DATA_W-1:0]            in_cmt_value,
    input  logic                         in_flush,
    output logic [CNT_W-1:0]             out_busy_count
);

    logic [DATA_W-1:0] values_q [REG_NUM];
    logic [DATA_W-1:0] values_d [REG_NUM];
    logic [ROB_W-1:0]  tags_q   [REG_NUM];
    logic [ROB_W-1:0]  tags_d   [REG_NUM];
    logic [REG_NUM-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic cmt_ok, ren_ok;

    // Register 0 and out-of-range indices are never written.
    assign cmt_ok = in_cmt_valid && (in_cmt_reg != '0) && (int'(in_cmt_reg) < int'(REG_NUM));
    assign ren_ok = in_ren_valid && (in_ren_reg != '0) && (int'(in_ren_reg) < int'(REG_NUM));

    // Next-state: commit first, then flush or rename, so rename wins over commit.
    always_comb begin
        values_d = values_q;
        tags_d   = tags_q;
        busy_d   = busy_q;
        if (rdy) begin
            if (cmt_ok) begin
                values_d[in_cmt_reg] = in_cmt_value;
                if (tags_q[in_cmt_reg] == in_cmt_rob) begin
                    busy_d[in_cmt_reg] = 1'b0;
                end
            end
            if (in_flush) begin
                busy_d = '0;
            end else if (ren_ok) begin
                busy_d[in_ren_reg] = 1'b1;
                tags_d[in_ren_reg] = in_ren_rob;
            end
        end
        values_d[0] = '0;
        tags_d[0]   = '0;
        busy_d[0]   = 1'b0;
    end

    // Busy count is a recount of the next-state busy vector, so it is always exact.
    always_comb begin
        count_d = '0;
        for (int i = 1; i < int'(REG_NUM); i++) begin
            count_d = count_d + CNT_W'(busy_d[i]);
        end
    end

    // State registers; synchronous reset overrides everything including rdy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(REG_NUM); i++) begin
                values_q[i] <= '0;
                tags_q[i]   <= '0;
            end
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            values_q <= values_d;
            tags_q   <= tags_d;
            busy_q   <= busy_d;
            count_q  <= count_d;
        end
    end

    assign out_busy_count = count_q;

    for (genvar p = 0; p < int'(NUM_READ); p++) begin : g_rd
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] value;
        logic [ROB_W-1:0]  tag;
        logic              busy;

        assign idx = in_rd_idx[p*IDX_W +: IDX_W];

        // Pre-update read, except a matching commit forwards its value and clears busy.
        always_comb begin
            value = '0;
            tag   = '0;
            busy  = 1'b0;
            if ((idx != '0) && (int'(idx) < int'(REG_NUM))) begin
                value = values_q[idx];
                tag   = tags_q[idx];
                busy  = busy_q[idx];
                if (in_cmt_valid && (in_cmt_reg == idx) && busy_q[idx] &&
                    (tags_q[idx] == in_cmt_rob)) begin
                    value = in_cmt_value;
                    busy  = 1'b0;
                end
            end
        end

        assign out_rd_value[p*DATA_W +: DATA_W] = value;
        assign out_rd_tag[p*ROB_W +: ROB_W]     = tag;
        assign out_rd_busy[p]                   = busy;
    end

endmodule

// File: tb/tb_regfile_rename_mp.sv
// Directed bench for regfile_rename_mp: reset, rename/commit with bypass,
// stale commit, same-cycle rename+commit, flush, x0, rdy hold and reset.
module tb_regfile_rename_mp;

    localparam int REG_NUM  = 32;
    localparam int DATA_W   = 32;
    localparam int ROB_W    = 4;
    localparam int NUM_READ = 2;
    localparam int IDX_W    = 5;
    localparam int CNT_W    = 6;

    logic                       clk = 1'b0;
    logic                       rst, rdy;
    logic [NUM_READ*IDX_W-1:0]  in_rd_idx;
    logic [NUM_READ*DATA_W-1:0] out_rd_value;
    logic [NUM_READ*ROB_W-1:0]  out_rd_tag;
    logic [NUM_READ-1:0]        out_rd_busy;
    logic                       in_ren_valid;
    logic [IDX_W-1:0]           in_ren_reg;
    logic [ROB_W-1:0]           in_ren_rob;
    logic                       in_cmt_valid;
    logic [IDX_W-1:0]           in_cmt_reg;
    logic [ROB_W-1:0]           in_cmt_rob;
    logic [DATA_W-1:0]          in_cmt_value;
    logic                       in_flush;
    logic [CNT_W-1:0]           out_busy_count;

    int tests = 0;
    int failed = 0;

    regfile_rename_mp #(
        .REG_NUM (REG_NUM),
        .DATA_W  (DATA_W),
        .ROB_W   (ROB_W),
        .NUM_READ(NUM_READ)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .in_rd_idx     (in_rd_idx),
        .out_rd_value  (out_rd_value),
        .out_rd_tag    (out_rd_tag),
        .out_rd_busy   (out_rd_busy),
        .in_ren_valid  (in_ren_valid),
        .in_ren_reg    (in_ren_reg),
        .in_ren_rob    (in_ren_rob),
        .in_cmt_valid  (in_cmt_valid),
        .in_cmt_reg    (in_cmt_reg),
        .in_cmt_rob    (in_cmt_rob),
        .in_cmt_value  (in_cmt_value),
        .in_flush      (in_flush),
        .out_busy_count(out_busy_count)
    );

    always #5 clk = ~clk;

    task automatic idle();
        rst = 1'b0; rdy = 1'b1; in_flush = 1'b0;
        in_ren_valid = 1'b0; in_ren_reg = '0; in_ren_rob = '0;
        in_cmt_valid = 1'b0; in_cmt_reg = '0; in_cmt_rob = '0; in_cmt_value = '0;
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [IDX_W-1:0] r0, input logic [IDX_W-1:0] r1);
        in_rd_idx = {r1, r0};
        #1;
    endtask

    task automatic rename(input logic [IDX_W-1:0] r, input logic [ROB_W-1:0] rob);
        in_ren_valid = 1'b1; in_ren_reg = r; in_ren_rob = rob;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        idle();
        set_rd(5'd1, 5'd0);
        tests++; if (out_rd_value !== 64'h0) begin failed++;
            $display("FAIL reset_value got %h exp %h", out_rd_value, 64'h0); end
        tests++; if (out_rd_tag !== 8'h0) begin failed++;
            $display("FAIL reset_tag got %h exp %h", out_rd_tag, 8'h0); end
        tests++; if (out_rd_busy !== 2'b00) begin failed++;
            $display("FAIL reset_busy got %b exp %b", out_rd_busy, 2'b00); end
        tests++; if (out_busy_count !== 6'd0) begin failed++;
            $display("FAIL reset_count got %0d exp %0d", out_busy_count, 0); end
    endtask

    task automatic test_rename_commit();
        rename(5'd5, 4'd3);
        set_rd(5'd5, 5'd5);
        tests++; if (out_rd_busy[0] !== 1'b1 || out_rd_tag[3:0] !== 4'd3) begin failed++;
            $display("FAIL ren_x5 got busy=%b tag=%0d exp busy=1 tag=3",
                     out_rd_busy[0], out_rd_tag[3:0]); end
        tests++; if (out_busy_count !== 6'd1) begin failed++;
            $display("FAIL ren_count got %0d exp 1", out_busy_count); end
        in_cmt_valid = 1'b1; in_cmt_reg = 5'd5; in_cmt_rob = 4'd3; in_cmt_value = 32'hDEAD_BEEF;
        #1;
        tests++; if (out_rd_value[63:32] !== 32'hDEAD_BEEF || out_rd_busy[1] !== 1'b0 ||
                     out_rd_tag[7:4] !== 4'd3) begin failed++;
            $display("FAIL bypass got val=%h busy=%b tag=%0d exp val=deadbeef busy=0 tag=3",
                     out_rd_value[63:32], out_rd_busy[1], out_rd_tag[7:4]); end
        tick();
        idle();
        #1;
        tests++; if (out_rd_value[31:0] !== 32'hDEAD_BEEF || out_rd_busy[0] !== 1'b0) begin
            failed++;
            $display("FAIL commit_x5 got val=%h busy=%b exp val=deadbeef busy=0",
                     out_rd_value[31:0], out_rd_busy[0]); end
        tests++; if (out_busy_count !== 6'd0) begin failed++;
            $display("FAIL commit_count got %0d exp 0", out_busy_count); end
    endtask

    task automatic test_stale_commit();
        rename(5'd7, 4'd2);
        rename(5'd7, 4'd6);
        set_rd(5'd7, 5'd0);
        in_cmt_valid = 1'b1; in_cmt_reg = 5'd7; in_cmt_rob = 4'd2; in_cmt_value = 32'h11;
        #1;
        tests++; if (out_rd_value[31:0] !== 32'h0 || out_rd_busy[0] !== 1'b1) begin failed++;
            $display("FAIL stale_no_bypass got val=%h busy=%b exp val=0 busy=1",
                     out_rd_value[31:0], out_rd_busy[0]); end
        tick();
        idle();
        #1;
        tests++; if (out_rd_value[31:0] !== 32'h11 || out_rd_busy[0] !== 1'b1 ||
                     out_rd_tag[3:0] !== 4'd6) begin failed++;
            $display("FAIL stale_x7 got val=%h busy=%b tag=%0d exp val=11 busy=1 tag=6",
                     out_rd_value[31:0], out_rd_busy[0], out_rd_tag[3:0]); end
        tests++; if (out_busy_count !== 6'd1) begin failed++;
            $display("FAIL stale_count got %0d exp 1", out_busy_count); end
    endtask

    task automatic test_same_cycle();
        rename(5'd9, 4'd4);
        set_rd(5'd9, 5'd7);
        tests++; if (out_busy_count !== 6'd2) begin failed++;
            $display("FAIL same_pre_count got %0d exp 2", out_busy_count); end
        in_cmt_valid = 1'b1; in_cmt_reg = 5'd9; in_cmt_rob = 4'd4; in_cmt_value = 32'h22;
        in_ren_valid = 1'b1; in_ren_reg = 5'd9; in_ren_rob = 4'd8;
        tick();
        idle();
        #1;
        tests++; if (out_rd_value[31:0] !== 32'h22 || out_rd_busy[0] !== 1'b1 ||
                     out_rd_tag[3:0] !== 4'd8) begin failed++;
            $display("FAIL same_x9 got val=%h busy=%b tag=%0d exp val=22 busy=1 tag=8",
                     out_rd_value[31:0], out_rd_busy[0], out_rd_tag[3:0]); end
        tests++; if (out_busy_count !== 6'd2) begin failed++;
            $display("FAIL same_count got %0d exp 2", out_busy_count); end
    endtask

    task automatic test_flush();
        rst = 1'b1;
        tick();
        idle();
        rename(5'd1, 4'd1);
        rename(5'd2, 4'd2);
        rename(5'd3, 4'd3);
        #1;
        tests++; if (out_busy_count !== 6'd3) begin failed++;
            $display("FAIL flush_pre_count got %0d exp 3", out_busy_count); end
        in_flush = 1'b1;
        in_ren_valid = 1'b1; in_ren_reg = 5'd4; in_ren_rob = 4'd9;
        in_cmt_valid = 1'b1; in_cmt_reg = 5'd1; in_cmt_rob = 4'd1; in_cmt_value = 32'h55;
        tick();
        idle();
        set_rd(5'd1, 5'd4);
        tests++; if (out_rd_value[31:0] !== 32'h55 || out_rd_busy !== 2'b00) begin failed++;
            $display("FAIL flush_x1_x4 got val=%h busy=%b exp val=55 busy=00",
                     out_rd_value[31:0], out_rd_busy); end
        set_rd(5'd2, 5'd3);
        tests++; if (out_rd_busy !== 2'b00 || out_rd_tag !== 8'h32) begin failed++;
            $display("FAIL flush_x2_x3 got busy=%b tag=%h exp busy=00 tag=32",
                     out_rd_busy, out_rd_tag); end
        tests++; if (out_busy_count !== 6'd0) begin failed++;
            $display("FAIL flush_count got %0d exp 0", out_busy_count); end
    endtask

    task automatic test_x0_rdy_rst();
        in_cmt_valid = 1'b1; in_cmt_reg = 5'd0; in_cmt_rob = 4'd0; in_cmt_value = 32'hFF;
        in_ren_valid = 1'b1; in_ren_reg = 5'd0; in_ren_rob = 4'd7;
        tick();
        idle();
        set_rd(5'd0, 5'd0);
        tests++; if (out_rd_value[31:0] !== 32'h0 || out_rd_busy[0] !== 1'b0 ||
                     out_busy_count !== 6'd0) begin failed++;
            $display("FAIL x0 got val=%h busy=%b cnt=%0d exp 0 0 0",
                     out_rd_value[31:0], out_rd_busy[0], out_busy_count); end
        rdy = 1'b0;
        in_ren_valid = 1'b1; in_ren_reg = 5'd10; in_ren_rob = 4'd5;
        tick();
        idle();
        set_rd(5'd10, 5'd0);
        tests++; if (out_rd_busy[0] !== 1'b0 || out_busy_count !== 6'd0) begin failed++;
            $display("FAIL rdy_hold_ren got busy=%b cnt=%0d exp 0 0",
                     out_rd_busy[0], out_busy_count); end
        rename(5'd10, 4'd5);
        rdy = 1'b0;
        in_cmt_valid = 1'b1; in_cmt_reg = 5'd10; in_cmt_rob = 4'd5; in_cmt_value = 32'h33;
        tick();
        idle();
        #1;
        tests++; if (out_rd_value[31:0] !== 32'h0 || out_rd_busy[0] !== 1'b1 ||
                     out_busy_count !== 6'd1) begin failed++;
            $display("FAIL rdy_hold_cmt got val=%h busy=%b cnt=%0d exp 0 1 1",
                     out_rd_value[31:0], out_rd_busy[0], out_busy_count); end
        rst = 1'b1;
        in_ren_valid = 1'b1; in_ren_reg = 5'd11; in_ren_rob = 4'd2;
        tick();
        idle();
        set_rd(5'd10, 5'd11);
        tests++; if (out_rd_busy !== 2'b00 || out_rd_tag !== 8'h00 ||
                     out_busy_count !== 6'd0) begin failed++;
            $display("FAIL rst_override got busy=%b tag=%h cnt=%0d exp 00 00 0",
                     out_rd_busy, out_rd_tag, out_busy_count); end
        set_rd(5'd1, 5'd9);
        tests++; if (out_rd_value !== 64'h0) begin failed++;
            $display("FAIL rst_values got %h exp 0", out_rd_value); end
    endtask

    initial begin
        in_rd_idx = '0;
        idle();
        test_reset();
        test_rename_commit();
        test_stale_commit();
        test_same_cycle();
        test_flush();
        test_x0_rdy_rst();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
